// File: rtl/sev_led_scanner.sv
// sev_led_scanner: time-multiplexed driver for a 4-digit common-cathode/anode display.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge) and asynchronous active-low reset
//   i_enable          1 = scan the display, 0 = display off (IDLE)
//   i_wr_valid/addr/data, o_wr_ready
//                     valid/ready write port into the shadow digit buffer
//   i_commit          request to copy shadow -> active at the next frame boundary
//   o_code            registered 4-bit code of the digit being scanned
//   o_digit_en        registered one-hot digit enable (all zero while blanking)
//   o_frame_done      one-cycle pulse during the last SHOW cycle of digit 3
//
// Each digit gets BLANK_CYCLES of all-off followed by SCAN_DIV cycles driven.
// o_code is presented during the blank window so a registered decoder downstream
// has settled before the digit enable turns on.
module sev_led_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_wr_valid,
    input  logic [1:0] i_wr_addr,
    input  logic [3:0] i_wr_data,
    output logic       o_wr_ready,
    input  logic       i_commit,
    output logic [3:0] o_code,
    output logic [3:0] o_digit_en,
    output logic       o_frame_done
);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_t;

    localparam logic [15:0] ShowLast  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BlankLast = 16'(BLANK_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_cnt;
    logic [3:0]  r_shadow [4];
    logic [3:0]  r_active [4];
    logic        r_pending;
    logic        r_wr_ready;
    logic [3:0]  r_code;
    logic [3:0]  r_digit_en;
    logic        r_frame_done;

    state_t      w_state_d;
    logic [1:0]  w_idx_d;
    logic [15:0] w_cnt_d;
    logic [3:0]  w_active_d [4];
    logic        w_pending_d;
    logic        w_copy;
    logic        w_wr_fire;
    logic [3:0]  w_code_d;
    logic [3:0]  w_digit_en_d;
    logic        w_frame_done_d;

    // Scan FSM next state.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_cnt_d   = r_cnt;
        if (!i_enable) begin
            w_state_d = StIdle;
            w_idx_d   = 2'd0;
            w_cnt_d   = 16'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_state_d = StBlank;
                    w_idx_d   = 2'd0;
                    w_cnt_d   = 16'd0;
                end
                StBlank: begin
                    if (r_cnt == BlankLast) begin
                        w_state_d = StShow;
                        w_cnt_d   = 16'd0;
                    end else begin
                        w_cnt_d = r_cnt + 16'd1;
                    end
                end
                StShow: begin
                    if (r_cnt == ShowLast) begin
                        w_state_d = StBlank;
                        w_idx_d   = r_idx + 2'd1;
                        w_cnt_d   = 16'd0;
                    end else begin
                        w_cnt_d = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_idx_d   = 2'd0;
                    w_cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // Buffer control. A commit lands only at a frame boundary (or straight away
    // when idle) so a digit never changes value partway through a frame.
    always_comb begin
        w_wr_fire   = i_wr_valid & r_wr_ready;
        w_copy      = r_pending & (r_frame_done | (r_state == StIdle));
        w_pending_d = w_copy ? 1'b0 : (r_pending | i_commit);
        for (int i = 0; i < 4; i++) begin
            w_active_d[i] = w_copy ? r_shadow[i] : r_active[i];
        end
    end

    // Outputs are registered from the next state so they line up with the state
    // they describe; the code uses the post-commit buffer for the same reason.
    always_comb begin
        w_code_d       = 4'd0;
        w_digit_en_d   = 4'd0;
        w_frame_done_d = 1'b0;
        if (w_state_d != StIdle) begin
            w_code_d = w_active_d[w_idx_d];
        end
        if (w_state_d == StShow) begin
            w_digit_en_d   = 4'b0001 << w_idx_d;
            w_frame_done_d = (w_idx_d == 2'd3) && (w_cnt_d == ShowLast);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_idx        <= 2'd0;
            r_cnt        <= 16'd0;
            r_pending    <= 1'b0;
            r_wr_ready   <= 1'b0;
            r_code       <= 4'd0;
            r_digit_en   <= 4'd0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 4'd0;
                r_active[i] <= 4'd0;
            end
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_cnt        <= w_cnt_d;
            r_pending    <= w_pending_d;
            r_wr_ready   <= ~w_pending_d;
            r_code       <= w_code_d;
            r_digit_en   <= w_digit_en_d;
            r_frame_done <= w_frame_done_d;
            for (int i = 0; i < 4; i++) begin
                r_active[i] <= w_active_d[i];
            end
            if (w_wr_fire) begin
                r_shadow[i_wr_addr] <= i_wr_data;
            end
        end
    end

    assign o_wr_ready   = r_wr_ready;
    assign o_code       = r_code;
    assign o_digit_en   = r_digit_en;
    assign o_frame_done = r_frame_done;

endmodule

// File: doc/sev_led_scanner.md
SEV_LED_SCANNER -- requirements
Module: sev_led_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each digit is driven in SHOW; legal range 2..65535.
REQ-002 Parameter BLANK_CYCLES, default 4, clock cycles all digits are off between digits; legal range 2..255.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_enable  input  1  level; 1 = scan the display, 0 = display off.
REQ-006 i_wr_valid  input  1  shadow-buffer write request.
REQ-007 i_wr_addr  input  2  digit index for the write (0..3).
REQ-008 i_wr_data  input  4  4-bit digit code for the write.
REQ-009 o_wr_ready  output  1  write acceptance; a write transfers when i_wr_valid and o_wr_ready are both 1.
REQ-010 i_commit  input  1  single-cycle request to copy the shadow buffer to the active buffer.
REQ-011 o_code  output  4  registered digit code; feeds the downstream decoder's 4-bit code input.
REQ-012 o_digit_en  output  4  registered one-hot digit enable, active-high; bit n selects digit n.
REQ-013 o_frame_done  output  1  one-cycle pulse at the end of each complete 4-digit frame.

Function
REQ-014 The block SHALL hold two 4x4-bit buffers: shadow (written via the handshake) and active (displayed).
REQ-015 An accepted write SHALL update shadow[i_wr_addr] on the same clock edge; the active buffer SHALL not change on a write.
REQ-016 o_wr_ready SHALL be 1 whenever no commit is pending and 0 while a commit is pending; writes with o_wr_ready=0 SHALL be dropped.
REQ-017 A commit becomes pending on any cycle where i_commit=1 and no commit is already pending; i_commit while pending SHALL be ignored.
REQ-018 When a write and i_commit occur in the same cycle with o_wr_ready=1, the write SHALL be accepted and SHALL be included in the committed data.
REQ-019 A pending commit SHALL copy all four shadow entries to active on the cycle o_frame_done is 1, or on the next cycle if the FSM is in IDLE; the pending flag SHALL clear on that same edge.
REQ-020 The FSM states SHALL be IDLE, BLANK and SHOW, with a 2-bit digit index and a 16-bit cycle counter.
REQ-021 IDLE: o_digit_en=0000, o_code=0000, index=0, counter=0; if i_enable=1, go to BLANK.
REQ-022 BLANK: o_digit_en=0000 and o_code=active[index]; after BLANK_CYCLES cycles, go to SHOW with the counter reset.
REQ-023 SHOW: o_digit_en=one-hot(index) and o_code=active[index]; after SCAN_DIV cycles, increment index modulo 4 and go to BLANK.
REQ-024 Leaving SHOW with index=3 SHALL assert o_frame_done for exactly that one cycle; index wraps to 0.
REQ-025 i_enable=0 in any state SHALL force IDLE on the next edge; no o_frame_done for a partial frame.
REQ-026 At most one o_digit_en bit SHALL be 1 in any cycle; all bits are 0 on every BLANK-to-SHOW and SHOW-to-BLANK boundary cycle.
REQ-027 o_code SHALL be stable for the entire BLANK+SHOW interval of a digit, so the downstream registered decoder settles within the blanking window.
REQ-028 The full frame period SHALL be exactly 4*(BLANK_CYCLES+SCAN_DIV) cycles while i_enable stays 1.

Reset
REQ-029 i_rst_n=0 SHALL immediately force: state=IDLE, index=0, counter=0, both buffers=0, pending=0, o_code=0000, o_digit_en=0000, o_frame_done=0, o_wr_ready=0.
REQ-030 o_wr_ready SHALL become 1 on the first rising edge after i_rst_n deasserts.
REQ-031 Reset asserted mid-SHOW or with a commit pending SHALL discard all state with no further output activity.

Verification (SCAN_DIV=8, BLANK_CYCLES=2)
REQ-032 Write digits 1,2,3,4 to addr 0..3, pulse i_commit, enable -> o_code sequence 1,2,3,4; o_digit_en 0001,0010,0100,1000, each 8 cycles with 2 blank cycles between; o_frame_done after 40 cycles.
REQ-033 With the display enabled, write 6 to addr 2 mid-frame, commit -> o_wr_ready=0 until frame end; digit 2 shows the old value in the current frame and 6 from the next frame.
REQ-034 Write plus i_commit in the same cycle, then write again while pending -> the first write is committed and the second is dropped (shadow unchanged).
REQ-035 Drop i_enable during SHOW of digit 1 -> next cycle o_digit_en=0000, o_code=0000, no o_frame_done; re-enable -> restarts at digit 0 with BLANK.
REQ-036 Assert i_rst_n=0 mid-SHOW with a commit pending -> outputs 0 asynchronously, buffers cleared, o_wr_ready=1 one edge after release.
REQ-037 Every cycle of every test -> o_digit_en is 0 or one-hot (assertion).
